// File: rtl/isa_burst_reader.sv
// Instruction-cache refill engine: splits a refill request into DDR read bursts of at most
// MAX_BURST beats and forwards one instruction per beat with a running delivered count.
module isa_burst_reader #(
    parameter int unsigned ISA_WIDTH      = 30,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned DDR_DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST      = 64,
    parameter int unsigned ADDR_STRIDE    = 8,
    parameter int unsigned CNT_WIDTH      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ISA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    input  logic [CNT_WIDTH-1:0]      isa_read_len,
    output logic [ISA_WIDTH-1:0]      instruction_to_cache,
    output logic                      rd_burst_data_valid,
    output logic [CNT_WIDTH-1:0]      rd_cnt_isa,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    output logic [CNT_WIDTH-1:0]      ddr_rd_len,
    input  logic                      ddr_rd_ack,
    input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
    input  logic                      ddr_rd_data_valid,
    input  logic                      ddr_rd_finish
);

    typedef enum logic [2:0] {StIdle, StReq, StRead, StDone, StDrain} state_e;

    localparam logic [CNT_WIDTH-1:0]      MaxBurst = CNT_WIDTH'(MAX_BURST);
    localparam logic [CNT_WIDTH-1:0]      CntOne   = CNT_WIDTH'(1);
    localparam logic [DDR_ADDR_WIDTH-1:0] Stride   = DDR_ADDR_WIDTH'(ADDR_STRIDE);

    state_e                    state_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]      len_q;
    logic [CNT_WIDTH-1:0]      remain_q;
    logic [CNT_WIDTH-1:0]      burst_len_q;
    logic [CNT_WIDTH-1:0]      beat_cnt_q;

    logic [CNT_WIDTH-1:0]      remain_next;
    logic [CNT_WIDTH-1:0]      clip_in;
    logic [CNT_WIDTH-1:0]      clip_next;
    logic [DDR_ADDR_WIDTH-1:0] addr_next;
    logic                      beat_ok;

    always_comb begin
        remain_next = remain_q - burst_len_q;
        addr_next   = addr_q + DDR_ADDR_WIDTH'(burst_len_q) * Stride;
        clip_in     = (isa_read_len > MaxBurst) ? MaxBurst : isa_read_len;
        clip_next   = (remain_next > MaxBurst) ? MaxBurst : remain_next;
        // Beats past the acknowledged burst length are never counted or forwarded.
        beat_ok     = ddr_rd_data_valid && (beat_cnt_q < burst_len_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= StIdle;
            addr_q               <= '0;
            len_q                <= '0;
            remain_q             <= '0;
            burst_len_q          <= '0;
            beat_cnt_q           <= '0;
            instruction_to_cache <= '0;
            rd_burst_data_valid  <= 1'b0;
            rd_cnt_isa           <= '0;
            ddr_rd_req           <= 1'b0;
            ddr_rd_addr          <= '0;
            ddr_rd_len           <= '0;
        end else begin
            rd_burst_data_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ISA_read_req) begin
                        len_q      <= isa_read_len;
                        rd_cnt_isa <= '0;
                        if (isa_read_len != '0) begin
                            addr_q      <= ISA_read_addr;
                            remain_q    <= isa_read_len;
                            ddr_rd_req  <= 1'b1;
                            ddr_rd_addr <= ISA_read_addr;
                            ddr_rd_len  <= clip_in;
                            state_q     <= StReq;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StReq: begin
                    if (ddr_rd_ack) begin
                        ddr_rd_req  <= 1'b0;
                        burst_len_q <= ddr_rd_len;
                        beat_cnt_q  <= '0;
                        state_q     <= ISA_read_req ? StRead : StDrain;
                    end else if (!ISA_read_req) begin
                        ddr_rd_req <= 1'b0;
                        rd_cnt_isa <= '0;
                        state_q    <= StIdle;
                    end
                end
                StRead: begin
                    if (beat_ok) begin
                        beat_cnt_q <= beat_cnt_q + CntOne;
                    end
                    if (!ISA_read_req) begin
                        // Abort: the rest of this burst is consumed silently.
                        if (ddr_rd_finish) begin
                            rd_cnt_isa <= '0;
                            state_q    <= StIdle;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        if (beat_ok) begin
                            rd_burst_data_valid  <= 1'b1;
                            instruction_to_cache <= ddr_rd_data[ISA_WIDTH-1:0];
                            if (rd_cnt_isa < len_q) begin
                                rd_cnt_isa <= rd_cnt_isa + CntOne;
                            end
                        end
                        if (ddr_rd_finish) begin
                            addr_q   <= addr_next;
                            remain_q <= remain_next;
                            if (remain_next != '0) begin
                                ddr_rd_req  <= 1'b1;
                                ddr_rd_addr <= addr_next;
                                ddr_rd_len  <= clip_next;
                                state_q     <= StReq;
                            end else begin
                                state_q <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    if (!ISA_read_req) begin
                        rd_cnt_isa <= '0;
                        state_q    <= StIdle;
                    end
                end
                StDrain: begin
                    if (ddr_rd_finish) begin
                        rd_cnt_isa <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    if (DDR_DATA_WIDTH > ISA_WIDTH) begin : g_unused_data
        logic unused_data_hi;
        assign unused_data_hi = ^ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
    end

endmodule

// File: tb/tb_isa_burst_reader.sv
// Scoreboard bench for isa_burst_reader: a DDR read-channel model pushes expected
// instructions as beats are driven; a negedge monitor pops and compares them.
module tb_isa_burst_reader;

    localparam int AW = 28;
    localparam int CW = 10;
    localparam int DW = 32;
    localparam int IW = 30;

    typedef struct {
        logic [IW-1:0] ins;
        logic [CW-1:0] cnt;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          isa_req = 1'b0;
    logic          sel = 1'b0;
    logic [AW-1:0] isa_addr = '0;
    logic [CW-1:0] isa_len = '0;
    logic          ack = 1'b0;
    logic          dvld = 1'b0;
    logic          fin = 1'b0;
    logic [DW-1:0] ddata = '0;

    logic [IW-1:0] instr0, instr1, mon_instr;
    logic          vld0, vld1, mon_vld;
    logic [CW-1:0] cnt0, cnt1, mon_cnt;
    logic          req0, req1, mon_req;
    logic [AW-1:0] baddr0, baddr1, mon_addr;
    logic [CW-1:0] blen0, blen1, mon_len;

    // dut0 uses MAX_BURST=64, dut1 uses MAX_BURST=1; sel routes the DDR model to one of them.
    isa_burst_reader #(.MAX_BURST(64)) dut0 (
        .clk(clk), .rst(rst), .ISA_read_req(isa_req & ~sel), .ISA_read_addr(isa_addr),
        .isa_read_len(isa_len), .instruction_to_cache(instr0), .rd_burst_data_valid(vld0),
        .rd_cnt_isa(cnt0), .ddr_rd_req(req0), .ddr_rd_addr(baddr0), .ddr_rd_len(blen0),
        .ddr_rd_ack(ack & ~sel), .ddr_rd_data(ddata), .ddr_rd_data_valid(dvld & ~sel),
        .ddr_rd_finish(fin & ~sel)
    );

    isa_burst_reader #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .ISA_read_req(isa_req & sel), .ISA_read_addr(isa_addr),
        .isa_read_len(isa_len), .instruction_to_cache(instr1), .rd_burst_data_valid(vld1),
        .rd_cnt_isa(cnt1), .ddr_rd_req(req1), .ddr_rd_addr(baddr1), .ddr_rd_len(blen1),
        .ddr_rd_ack(ack & sel), .ddr_rd_data(ddata), .ddr_rd_data_valid(dvld & sel),
        .ddr_rd_finish(fin & sel)
    );

    assign mon_instr = sel ? instr1 : instr0;
    assign mon_vld   = sel ? vld1 : vld0;
    assign mon_cnt   = sel ? cnt1 : cnt0;
    assign mon_req   = sel ? req1 : req0;
    assign mon_addr  = sel ? baddr1 : baddr0;
    assign mon_len   = sel ? blen1 : blen0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    beat_t               exp_q[$];
    logic [AW+CW-1:0]    burst_q[$];
    int                  m_state = 0;
    int                  m_wait = 0;
    int                  m_left = 0;
    int                  stray = 0;
    bit                  kill = 1'b0;
    int                  fwd_cnt = 0;
    int                  cur_len = 0;
    logic [AW-1:0]       m_addr = '0;
    logic [CW-1:0]       m_len = '0;

    // DDR read-channel model: acks 3 cycles after a request, then streams beats with gaps.
    initial begin
        logic [AW-1:0] ea;
        logic [CW-1:0] el;
        forever begin
            @(posedge clk);
            #2;
            ack  = 1'b0;
            dvld = 1'b0;
            fin  = 1'b0;
            if (kill) begin
                m_state = 0;
                kill    = 1'b0;
            end else if (stray > 0) begin
                dvld  = 1'b1;
                ddata = $urandom;
                stray--;
                fin   = (stray == 0);
            end else begin
                case (m_state)
                    0: if (mon_req) begin
                        if (burst_q.size() == 0) begin
                            check("unexpected_req", mon_req, 1'b0);
                        end else begin
                            {ea, el} = burst_q.pop_front();
                            check("req_addr", mon_addr, ea);
                            check("req_len", mon_len, el);
                        end
                        m_addr  = mon_addr;
                        m_len   = mon_len;
                        m_wait  = 3;
                        m_state = 1;
                    end
                    1: begin
                        check("req_hold", {mon_req, mon_addr, mon_len}, {1'b1, m_addr, m_len});
                        m_wait--;
                        if (m_wait == 0) begin
                            ack     = 1'b1;
                            m_left  = int'(m_len);
                            m_state = 2;
                        end
                    end
                    default: if ($urandom_range(3) != 0) begin
                        dvld  = 1'b1;
                        ddata = $urandom;
                        m_left--;
                        if (isa_req && fwd_cnt < cur_len) begin
                            fwd_cnt++;
                            exp_q.push_back('{ins: ddata[IW-1:0], cnt: CW'(fwd_cnt)});
                        end
                        if (m_left == 0) begin
                            fin     = 1'b1;
                            m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (mon_vld) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", mon_vld, 1'b0);
            end else begin
                b = exp_q.pop_front();
                check("instr", mon_instr, b.ins);
                check("cnt", mon_cnt, b.cnt);
            end
        end
    end

    task automatic start_req(input bit s, input logic [AW-1:0] a, input int len, input int maxb);
        logic [AW-1:0] ba = a;
        int rem = len;
        while (rem > 0) begin
            int b = (rem < maxb) ? rem : maxb;
            burst_q.push_back({ba, CW'(b)});
            ba = ba + AW'(b * 8);
            rem -= b;
        end
        @(posedge clk);
        #1;
        sel      = s;
        cur_len  = len;
        fwd_cnt  = 0;
        isa_addr = a;
        isa_len  = CW'(len);
        isa_req  = 1'b1;
        @(posedge clk);
        #1;
        isa_addr = AW'($urandom);
        isa_len  = CW'($urandom);
    endtask

    task automatic wait_cnt(input string tag, input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = (mon_cnt == CW'(target));
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic run_req(input bit s, input logic [AW-1:0] a, input int len, input int maxb);
        bit ok = 1'b0;
        start_req(s, a, len, maxb);
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = (mon_cnt == CW'(len)) && exp_q.size() == 0 && burst_q.size() == 0
                 && m_state == 0;
        end
        check("done", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_cnt", mon_cnt, CW'(len));
        check("hold_noreq", mon_req, 1'b0);
        @(posedge clk);
        #1;
        isa_req = 1'b0;
        repeat (2) @(negedge clk);
        check("clear_cnt", mon_cnt, '0);
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_vld", mon_vld, 1'b0);
        check("rst_cnt", mon_cnt, '0);
        check("rst_req", mon_req, 1'b0);
        check("rst_addr", mon_addr, '0);
        check("rst_len", mon_len, '0);
        check("rst_instr", mon_instr, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_req(1'b0, AW'('h100), 16, 64);
        run_req(1'b0, '0, 128, 64);
        run_req(1'b0, '0, 100, 64);
        run_req(1'b0, AW'('h40), 0, 64);
        run_req(1'b1, AW'(28'hFFFFFF8), 2, 1);

        // Abort mid-burst: drop the request once 5 instructions have been delivered.
        start_req(1'b0, AW'('h200), 16, 64);
        wait_cnt("abort_reach5", 5);
        @(posedge clk);
        #1;
        isa_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = (m_state == 0);
        end
        check("abort_drained", ok, 1'b1);
        repeat (4) @(negedge clk);
        check("abort_cnt", mon_cnt, '0);
        check("abort_noreq", mon_req, 1'b0);
        check("abort_exp_left", exp_q.size(), 0);

        // Reset mid-burst at beat 3, then stray beats.
        start_req(1'b0, AW'('h400), 16, 64);
        wait_cnt("rst_reach3", 3);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        isa_req = 1'b0;
        kill    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        burst_q.delete();
        stray = 5;
        @(negedge clk);
        check("mid_rst_vld", mon_vld, 1'b0);
        check("mid_rst_cnt", mon_cnt, '0);
        check("mid_rst_req", mon_req, 1'b0);
        check("mid_rst_addr", mon_addr, '0);
        check("mid_rst_len", mon_len, '0);
        check("mid_rst_instr", mon_instr, '0);
        repeat (8) @(negedge clk);
        check("stray_cnt", mon_cnt, '0);
        check("stray_noreq", mon_req, 1'b0);
        run_req(1'b0, AW'('h300), 28, 64);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isa_burst_reader.md
Name: isa_burst_reader

Overview:
Upstream feeder of the instruction cache. Accepts a cache refill request (start address, length in instructions), splits it into DDR read bursts of at most MAX_BURST beats, and returns one instruction per beat with a running beat count. It sits between the instruction cache and the DDR controller's read channel.

Parameters:
ISA_WIDTH, 30, instruction width; the low ISA_WIDTH bits of each DDR beat are taken.
DDR_ADDR_WIDTH, 28, DDR address width.
DDR_DATA_WIDTH, 32, DDR read data width; must be >= ISA_WIDTH.
MAX_BURST, 64, maximum beats per DDR burst, range 1..512.
ADDR_STRIDE, 8, DDR address increment per beat.
CNT_WIDTH, 10, width of the length and count fields.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ISA_read_req  in  1  refill request level from the cache; held until the count reaches the length
ISA_read_addr  in  DDR_ADDR_WIDTH  start DDR address, sampled in IDLE
isa_read_len  in  CNT_WIDTH  instructions to fetch, sampled in IDLE
instruction_to_cache  out  ISA_WIDTH  returned instruction
rd_burst_data_valid  out  1  instruction_to_cache valid this cycle
rd_cnt_isa  out  CNT_WIDTH  instructions delivered so far for the current request
ddr_rd_req  out  1  burst request to the DDR controller
ddr_rd_addr  out  DDR_ADDR_WIDTH  burst start address
ddr_rd_len  out  CNT_WIDTH  burst length in beats
ddr_rd_ack  in  1  DDR controller accepted the burst request
ddr_rd_data  in  DDR_DATA_WIDTH  read beat data
ddr_rd_data_valid  in  1  read beat valid
ddr_rd_finish  in  1  one-cycle pulse when the last beat of a burst has been returned

Behaviour:
- Reset (rst=1 on a clk edge): state goes to IDLE. All outputs are 0 and all internal counters are 0. Any burst in flight is abandoned. Beats that arrive after reset are ignored.
- States: IDLE, REQ, READ, DONE, DRAIN.
- IDLE:
  - If ISA_read_req=1 and isa_read_len>0: latch addr and len, set remain=len, go to REQ.
  - If ISA_read_req=1 and len=0: go to DONE with rd_cnt_isa=0.
  - Beats arriving in IDLE are dropped.
- REQ:
  - Drive ddr_rd_req=1, ddr_rd_addr=current addr, and ddr_rd_len=min(remain, MAX_BURST).
  - Hold all three stable until ddr_rd_ack. On the ack cycle, ddr_rd_req drops and the state goes to READ.
  - If ISA_read_req drops before the ack: go to IDLE with no burst issued.
- READ:
  - Each ddr_rd_data_valid beat is registered. One cycle later, rd_burst_data_valid=1 and instruction_to_cache=ddr_rd_data[ISA_WIDTH-1:0]. rd_cnt_isa increments in that same cycle, so rd_cnt_isa already counts the beat being presented. Latency is 1 cycle.
  - Beats beyond the requested burst length are dropped.
  - On ddr_rd_finish:
    - addr += burst_len*ADDR_STRIDE (wraps modulo 2^DDR_ADDR_WIDTH);
    - remain -= burst_len;
    - if remain>0 go to REQ, otherwise go to DONE.
  - A beat and ddr_rd_finish in the same cycle: the beat counts.
- DONE:
  - rd_cnt_isa holds its final value (equal to len) while ISA_read_req=1. No DDR traffic.
  - When ISA_read_req=0: go to IDLE and clear rd_cnt_isa to 0.
  - A new request needs at least one cycle of ISA_read_req=0.
- DRAIN:
  - Entered from READ when ISA_read_req drops mid-burst.
  - Remaining beats of the current burst are consumed but not forwarded.
  - On ddr_rd_finish: go to IDLE and clear rd_cnt_isa to 0.
- ISA_read_addr and isa_read_len changing after IDLE have no effect on the current request.
- rd_cnt_isa never exceeds len; it saturates if the DDR side misbehaves.

Test Plan:
- Single burst: addr=0x100, len=16, MAX_BURST=64, DDR acks after 3 cycles. Required: exactly one request with ddr_rd_addr=0x100 and ddr_rd_len=16; 16 valid pulses, each 1 cycle after its beat; rd_cnt_isa goes 1..16 and holds at 16 until the request drops, then returns to 0.
- Split burst: addr=0, len=128, MAX_BURST=64. Required: two requests, (addr 0, len 64) then (addr 512, len 64); rd_cnt_isa is continuous from 1 to 128.
- Odd tail: len=100, MAX_BURST=64. Required: bursts of 64 then 36; the second is at addr 512; final rd_cnt_isa=100.
- Abort: ISA_read_req drops after beat 5 of 16. Required: no further rd_burst_data_valid; the remaining 11 beats are drained; IDLE after ddr_rd_finish; rd_cnt_isa=0; no new ddr_rd_req.
- Reset mid-burst: rst=1 for 1 cycle at beat 3, then stray beats arrive. Required: all outputs 0 and stray beats ignored. A next request with len=28 completes normally with rd_cnt_isa=28.
- Zero length and address wrap: len=0 gives DONE with no ddr_rd_req. Start addr=2^28-8 with len=2 and MAX_BURST=1 gives the second burst at addr 0.
